// File: rtl/npc_gen.sv
// npc_gen: next-PC selection for the fetch stage.
// Chooses between sequential fetch, EX-stage redirects and the trap vector.
// A redirect that arrives during a front-end stall is held until the stall
// clears, because the PC register ignores NPC while stalled. Misaligned
// redirect targets are steered to the trap vector and flagged, and every
// applied redirect is counted.
module npc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic [31:0] NPC,
  output logic        flush,
  output logic        misalign,
  output logic        pending,
  output logic [31:0] redir_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] held_target_r;
  logic        misalign_r;
  logic        pending_r;
  logic [31:0] redir_count_r;

  logic        apply_s;
  logic [31:0] apply_target_s;
  logic        apply_misaligned_s;
  logic        latch_s;
  logic [31:0] seq_pc_s;

  // A fetch target must be word aligned; any low address bit set traps.
  function automatic logic is_misaligned(input logic [31:0] addr);
    is_misaligned = (addr[1:0] != 2'b00);
  endfunction

  assign seq_pc_s = PC + 32'd4;

  // Decide whether a redirect is applied this cycle and which target it uses.
  // Reset suppresses everything, so a held redirect can never leak out.
  always_comb begin
    apply_s        = 1'b0;
    apply_target_s = 32'h0000_0000;
    latch_s        = 1'b0;
    state_next_s   = state_r;
    if (rst) begin
      apply_s        = 1'b0;
      apply_target_s = 32'h0000_0000;
      latch_s        = 1'b0;
      state_next_s   = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (redir_valid && !stall) begin
            apply_s        = 1'b1;
            apply_target_s = redir_target;
          end else if (redir_valid && stall) begin
            latch_s      = 1'b1;
            state_next_s = HELD;
          end else begin
            apply_s = 1'b0;
          end
        end
        HELD: begin
          // New redirects are ignored here: the held one is older and
          // flushes the instruction that produced the younger one.
          if (!stall) begin
            apply_s        = 1'b1;
            apply_target_s = held_target_r;
            state_next_s   = IDLE;
          end else begin
            apply_s = 1'b0;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  assign apply_misaligned_s = apply_s && is_misaligned(apply_target_s);

  // Select the value presented to the PC register and the IF/ID flush.
  always_comb begin
    NPC   = seq_pc_s;
    flush = 1'b0;
    if (rst) begin
      NPC   = RESET_VECTOR;
      flush = 1'b0;
    end else if (apply_s) begin
      flush = 1'b1;
      if (apply_misaligned_s) begin
        NPC = TRAP_VECTOR;
      end else begin
        NPC = apply_target_s;
      end
    end else if (state_r == HELD) begin
      // Stalled with a held redirect; the PC register ignores this value,
      // but presenting the held target keeps NPC stable across the stall.
      NPC   = held_target_r;
      flush = 1'b0;
    end else begin
      NPC   = seq_pc_s;
      flush = 1'b0;
    end
  end

  // Redirect FSM, held target, misalign pulse, pending flag and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      held_target_r <= 32'h0000_0000;
      misalign_r    <= 1'b0;
      pending_r     <= 1'b0;
      redir_count_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_next_s;
      misalign_r <= apply_misaligned_s;
      pending_r  <= (state_next_s == HELD);
      if (latch_s) begin
        held_target_r <= redir_target;
      end
      if (apply_s) begin
        redir_count_r <= redir_count_r + 32'd1;
      end
    end
  end

  assign misalign    = misalign_r;
  assign pending     = pending_r;
  assign redir_count = redir_count_r;

endmodule

// File: tb/tb_npc_gen.sv
// tb_npc_gen: directed self-checking bench for npc_gen.
// Inputs change on the falling edge; combinational outputs are checked #1
// later, registered outputs are checked after the following rising edge.
module tb_npc_gen;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] NPC;
  logic        flush;
  logic        misalign;
  logic        pending;
  logic [31:0] redir_count;

  int checks;
  int errors;

  npc_gen dut (
    .clk          (clk),
    .rst          (rst),
    .PC           (PC),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .NPC          (NPC),
    .flush        (flush),
    .misalign     (misalign),
    .pending      (pending),
    .redir_count  (redir_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic s, input logic v,
                       input logic [31:0] t, input logic [31:0] pc);
    @(negedge clk);
    rst          = r;
    stall        = s;
    redir_valid  = v;
    redir_target = t;
    PC           = pc;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_1234);
      checks++;
      if (NPC !== 32'h0 || flush !== 1'b0) begin
        errors++;
        $display("FAIL reset_npc: NPC=%h flush=%b, want 0 0", NPC, flush);
      end
    end
    // Released with no redirects: PC register walks 0,4,8,12.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'(i * 4));
      checks++;
      if (NPC !== 32'(i * 4 + 4) || flush !== 1'b0 || pending !== 1'b0 ||
          redir_count !== 32'h0 || misalign !== 1'b0) begin
        errors++;
        $display("FAIL seq_fetch: NPC=%h flush=%b pend=%b cnt=%h mis=%b, want %h 0 0 0 0",
                 NPC, flush, pending, redir_count, misalign, 32'(i * 4 + 4));
      end
    end
  endtask

  task automatic test_redirect;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0040);
    checks++;
    if (NPC !== 32'h0000_0200 || flush !== 1'b1) begin
      errors++;
      $display("FAIL redirect_same_cycle: NPC=%h flush=%b, want 00000200 1", NPC, flush);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0200);
    checks++;
    if (redir_count !== 32'd1 || misalign !== 1'b0 || flush !== 1'b0 || NPC !== 32'h0000_0204) begin
      errors++;
      $display("FAIL redirect_after: cnt=%h mis=%b flush=%b NPC=%h, want 1 0 0 00000204",
               redir_count, misalign, flush, NPC);
    end
  endtask

  task automatic test_held;
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0204);
    checks++;
    if (flush !== 1'b0 || NPC !== 32'h0000_0208 || pending !== 1'b0) begin
      errors++;
      $display("FAIL held_latch: flush=%b NPC=%h pend=%b, want 0 00000208 0", flush, NPC, pending);
    end
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0204);
    checks++;
    if (pending !== 1'b1 || NPC !== 32'h0000_0300 || flush !== 1'b0) begin
      errors++;
      $display("FAIL held_ignore: pend=%b NPC=%h flush=%b, want 1 00000300 0", pending, NPC, flush);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0204);
    checks++;
    if (pending !== 1'b1 || NPC !== 32'h0000_0300 || redir_count !== 32'd1) begin
      errors++;
      $display("FAIL held_hold: pend=%b NPC=%h cnt=%h, want 1 00000300 1", pending, NPC, redir_count);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0204);
    checks++;
    if (NPC !== 32'h0000_0300 || flush !== 1'b1) begin
      errors++;
      $display("FAIL held_release: NPC=%h flush=%b, want 00000300 1", NPC, flush);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0300);
    checks++;
    if (pending !== 1'b0 || redir_count !== 32'd2 || flush !== 1'b0 || NPC !== 32'h0000_0304) begin
      errors++;
      $display("FAIL held_after: pend=%b cnt=%h flush=%b NPC=%h, want 0 2 0 00000304",
               pending, redir_count, flush, NPC);
    end
  endtask

  task automatic test_misalign;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0202, 32'h0000_0304);
    checks++;
    if (NPC !== 32'h0000_0100 || flush !== 1'b1) begin
      errors++;
      $display("FAIL misalign_trap: NPC=%h flush=%b, want 00000100 1", NPC, flush);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0100);
    checks++;
    if (misalign !== 1'b1 || redir_count !== 32'd3) begin
      errors++;
      $display("FAIL misalign_pulse: mis=%b cnt=%h, want 1 3", misalign, redir_count);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0104);
    checks++;
    if (misalign !== 1'b0 || redir_count !== 32'd3) begin
      errors++;
      $display("FAIL misalign_clear: mis=%b cnt=%h, want 0 3", misalign, redir_count);
    end
  endtask

  task automatic test_wrap;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
    checks++;
    if (NPC !== 32'h0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL pc_wrap: NPC=%h flush=%b, want 00000000 0", NPC, flush);
    end
    // Preload the counter to its maximum before one more redirect.
    @(negedge clk);
    dut.redir_count_r = 32'hFFFF_FFFF;
    rst          = 1'b0;
    stall        = 1'b0;
    redir_valid  = 1'b1;
    redir_target = 32'h0000_0200;
    PC           = 32'h0000_0010;
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0200);
    checks++;
    if (redir_count !== 32'h0) begin
      errors++;
      $display("FAIL count_wrap: cnt=%h, want 00000000", redir_count);
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_0200);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0800, 32'h0000_0400);
    checks++;
    if (NPC !== 32'h0000_0800 || flush !== 1'b1 || redir_count !== 32'd1) begin
      errors++;
      $display("FAIL b2b_second: NPC=%h flush=%b cnt=%h, want 00000800 1 1", NPC, flush, redir_count);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0800);
    checks++;
    if (redir_count !== 32'd2 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: cnt=%h mis=%b, want 2 0", redir_count, misalign);
    end
  endtask

  task automatic test_reset_held;
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0804);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0804);
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL rh_pending: pend=%b, want 1", pending);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0804);
    checks++;
    if (NPC !== 32'h0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL rh_reset: NPC=%h flush=%b, want 00000000 0", NPC, flush);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (pending !== 1'b0 || redir_count !== 32'h0 || misalign !== 1'b0 ||
        flush !== 1'b0 || NPC !== 32'h0000_0004) begin
      errors++;
      $display("FAIL rh_after: pend=%b cnt=%h mis=%b flush=%b NPC=%h, want 0 0 0 0 00000004",
               pending, redir_count, misalign, flush, NPC);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    stall        = 1'b0;
    redir_valid  = 1'b0;
    redir_target = 32'h0;
    PC           = 32'h0;
    test_reset();
    test_redirect();
    test_held();
    test_misalign();
    test_wrap();
    test_back_to_back();
    test_reset_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
